// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - per-player PS/2 + joystick merge, SOCD cleanup and coin pulse shaping
// Optional autofire on fire1 is built only when INPUT_AUTOFIRE_EN is defined.
module arcade_input_mapper #(
    parameter int NPLAYERS       = 2,
    parameter int COIN_PULSE_CYC = 120000,
    parameter int AUTOFIRE_DIV   = 400000
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [10:0]             ps2_key,
    input  logic [16*NPLAYERS-1:0]  joystick,
    input  logic [NPLAYERS-1:0]     af_enable,
    output logic [8*NPLAYERS-1:0]   pad
);

    localparam int CW = $clog2(COIN_PULSE_CYC + 1);

    typedef enum logic [1:0] {
        COIN_IDLE,
        COIN_PULSE,
        COIN_HOLD
    } coin_state_t;

    logic                 tog_q;
    logic                 ps2_event;
    logic [1:0][7:0]      key_q;
    logic [1:0][7:0]      key_hit;
    logic [8*NPLAYERS-1:0] pad_d;

    assign ps2_event = ps2_key[10] != tog_q;

    // Latch bit order matches the pad word: U D L R F1 F2 Start Coin.
    always_comb begin
        key_hit = '0;
        case (ps2_key[7:0])
            8'h75:   key_hit[0][0] = 1'b1;
            8'h72:   key_hit[0][1] = 1'b1;
            8'h6B:   key_hit[0][2] = 1'b1;
            8'h74:   key_hit[0][3] = 1'b1;
            default: ;
        endcase
        if (!ps2_key[8]) begin
            case (ps2_key[7:0])
                8'h29:        key_hit[0][4] = 1'b1;
                8'h14:        key_hit[0][5] = 1'b1;
                8'h05, 8'h16: key_hit[0][6] = 1'b1;
                8'h2E:        key_hit[0][7] = 1'b1;
                8'h2D:        key_hit[1][0] = 1'b1;
                8'h2B:        key_hit[1][1] = 1'b1;
                8'h23:        key_hit[1][2] = 1'b1;
                8'h34:        key_hit[1][3] = 1'b1;
                8'h1C:        key_hit[1][4] = 1'b1;
                8'h1B:        key_hit[1][5] = 1'b1;
                8'h06, 8'h1E: key_hit[1][6] = 1'b1;
                8'h36:        key_hit[1][7] = 1'b1;
                default: ;
            endcase
        end
    end

    // tog_q tracks the toggle even in reset so releasing reset never looks like an event.
    always_ff @(posedge clk_sys) begin
        tog_q <= ps2_key[10];
        if (reset) begin
            key_q <= '0;
        end else if (ps2_event) begin
            for (int p = 0; p < 2; p++) begin
                for (int b = 0; b < 8; b++) begin
                    if (key_hit[p][b]) key_q[p][b] <= ps2_key[9];
                end
            end
        end
    end

`ifdef INPUT_AUTOFIRE_EN
    localparam int AW = $clog2(AUTOFIRE_DIV + 1);

    logic [AW-1:0] af_cnt_q;
    logic          af_phase_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b1;
        end else if (af_cnt_q == AW'(AUTOFIRE_DIV - 1)) begin
            af_cnt_q   <= '0;
            af_phase_q <= ~af_phase_q;
        end else begin
            af_cnt_q   <= af_cnt_q + AW'(1);
        end
    end
`else
    logic unused_af;
    assign unused_af = ^af_enable;
`endif

    for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
        logic [15:0]  joy;
        logic [7:0]   kbd;
        logic [7:0]   raw;
        logic [3:0]   dirs;
        logic         fire1;
        logic         unused_joy;
        coin_state_t  cs_q, cs_d;
        logic [CW-1:0] cnt_q, cnt_d;

        assign joy        = joystick[16*p +: 16];
        assign unused_joy = ^{joy[15:9], joy[7]};

        if (p < 2) begin : g_kbd
            assign kbd = key_q[p];
        end else begin : g_nokbd
            assign kbd = '0;
        end

        assign raw = kbd | {joy[8], joy[6], joy[5], joy[4], joy[0], joy[1], joy[2], joy[3]};

        // Opposing directions cancel rather than one side winning.
        assign dirs[1:0] = (raw[0] & raw[1]) ? 2'b00 : raw[1:0];
        assign dirs[3:2] = (raw[2] & raw[3]) ? 2'b00 : raw[3:2];

`ifdef INPUT_AUTOFIRE_EN
        assign fire1 = raw[4] & (af_phase_q | ~af_enable[p]);
`else
        assign fire1 = raw[4];
`endif

        always_comb begin
            cs_d  = cs_q;
            cnt_d = cnt_q;
            case (cs_q)
                COIN_IDLE: begin
                    if (raw[7]) begin
                        cs_d  = COIN_PULSE;
                        cnt_d = '0;
                    end
                end
                COIN_PULSE: begin
                    if (cnt_q == CW'(COIN_PULSE_CYC - 1)) begin
                        cs_d  = COIN_HOLD;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                COIN_HOLD: begin
                    if (!raw[7]) cs_d = COIN_IDLE;
                end
                default: begin
                    cs_d  = COIN_IDLE;
                    cnt_d = '0;
                end
            endcase
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                cs_q  <= COIN_IDLE;
                cnt_q <= '0;
            end else begin
                cs_q  <= cs_d;
                cnt_q <= cnt_d;
            end
        end

        // Coin bit uses the next state so the pulse lines up with the pad register.
        assign pad_d[8*p +: 8] = {cs_d == COIN_PULSE, raw[6:5], fire1, dirs};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) pad <= '0;
        else       pad <= pad_d;
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb/tb_arcade_input_mapper.sv - vector table, directed corner cases and random run against a reference model
module tb_arcade_input_mapper;

    localparam int NP = 2;
    localparam int CP = 8;
    localparam int AD = 4;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [31:0] joystick;
    logic [1:0]  af_enable;
    logic [15:0] pad;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .NPLAYERS(NP),
        .COIN_PULSE_CYC(CP),
        .AUTOFIRE_DIV(AD)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .ps2_key(ps2_key),
        .joystick(joystick),
        .af_enable(af_enable),
        .pad(pad)
    );

    typedef struct {
        bit         any_ext;
        bit         ext;
        logic [7:0] code;
        int         player;
        int         func;
    } key_ent_t;

    typedef struct {
        logic [31:0] joy;
        logic [15:0] exp;
    } vec_t;

    key_ent_t ktab[18];
    vec_t     vt[13];
    int       jmap[8] = '{3, 2, 1, 0, 4, 5, 6, 8};

    int  checks = 0;
    int  errors = 0;
    bit  m_key[2][8];
    int  m_left[2];
    bit  m_armed[2];
    bit  m_tog;
    int  m_k;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: predict pad from model state and inputs, advance the model, then compare.
    task automatic step(input string name);
        logic [15:0] nxt;
        bit          r[8];
        bit          co;
        bit          phase;
        int          nleft[2];
        bit          narm[2];
        nxt   = '0;
        phase = ((m_k / AD) % 2) == 0;
        for (int p = 0; p < 2; p++) begin
            for (int f = 0; f < 8; f++) r[f] = m_key[p][f] | joystick[16*p + jmap[f]];
            if (r[0] && r[1]) begin r[0] = 0; r[1] = 0; end
            if (r[2] && r[3]) begin r[2] = 0; r[3] = 0; end
`ifdef INPUT_AUTOFIRE_EN
            r[4] = r[4] & (phase | !af_enable[p]);
`endif
            nleft[p] = m_left[p];
            narm[p]  = m_armed[p];
            if (m_left[p] > 0) begin
                co = 1; nleft[p] = m_left[p] - 1;
            end else if (!m_armed[p]) begin
                co = 0; if (!r[7]) narm[p] = 1;
            end else if (r[7]) begin
                co = 1; nleft[p] = CP - 1; narm[p] = 0;
            end else begin
                co = 0;
            end
            for (int f = 0; f < 7; f++) nxt[8*p + f] = r[f];
            nxt[8*p + 7] = co;
        end
        if (reset) begin
            nxt = '0;
            for (int p = 0; p < 2; p++) begin
                m_left[p] = 0; m_armed[p] = 1;
                for (int f = 0; f < 8; f++) m_key[p][f] = 0;
            end
            m_k = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin m_left[p] = nleft[p]; m_armed[p] = narm[p]; end
            m_k++;
            if (ps2_key[10] != m_tog) begin
                foreach (ktab[i]) begin
                    if (ps2_key[7:0] == ktab[i].code && (ktab[i].any_ext || ps2_key[8] == ktab[i].ext))
                        m_key[ktab[i].player][ktab[i].func] = ps2_key[9];
                end
            end
        end
        m_tog = ps2_key[10];
        @(posedge clk_sys);
        #1;
        checks++;
        if (pad !== nxt) begin
            errors++;
            $display("FAIL %s pad=%h expected %h", name, pad, nxt);
        end
    endtask

    task automatic ps2(input bit pressed, input bit ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
        step("ps2_event");
    endtask

    int cnt;
    int tmp;

    initial begin
        ktab[0]  = '{1, 0, 8'h75, 0, 0};
        ktab[1]  = '{1, 0, 8'h72, 0, 1};
        ktab[2]  = '{1, 0, 8'h6B, 0, 2};
        ktab[3]  = '{1, 0, 8'h74, 0, 3};
        ktab[4]  = '{0, 0, 8'h29, 0, 4};
        ktab[5]  = '{0, 0, 8'h14, 0, 5};
        ktab[6]  = '{0, 0, 8'h05, 0, 6};
        ktab[7]  = '{0, 0, 8'h16, 0, 6};
        ktab[8]  = '{0, 0, 8'h2E, 0, 7};
        ktab[9]  = '{0, 0, 8'h2D, 1, 0};
        ktab[10] = '{0, 0, 8'h2B, 1, 1};
        ktab[11] = '{0, 0, 8'h23, 1, 2};
        ktab[12] = '{0, 0, 8'h34, 1, 3};
        ktab[13] = '{0, 0, 8'h1C, 1, 4};
        ktab[14] = '{0, 0, 8'h1B, 1, 5};
        ktab[15] = '{0, 0, 8'h06, 1, 6};
        ktab[16] = '{0, 0, 8'h1E, 1, 6};
        ktab[17] = '{0, 0, 8'h36, 1, 7};

        vt[0]  = '{32'h0000_0008, 16'h0001};
        vt[1]  = '{32'h0000_0004, 16'h0002};
        vt[2]  = '{32'h0000_000C, 16'h0000};
        vt[3]  = '{32'h0000_0002, 16'h0004};
        vt[4]  = '{32'h0000_0001, 16'h0008};
        vt[5]  = '{32'h0000_0003, 16'h0000};
        vt[6]  = '{32'h0000_000F, 16'h0000};
        vt[7]  = '{32'h0000_0010, 16'h0010};
        vt[8]  = '{32'h0000_0020, 16'h0020};
        vt[9]  = '{32'h0000_0040, 16'h0040};
        vt[10] = '{32'h0000_0009, 16'h0009};
        vt[11] = '{32'h0008_0000, 16'h0100};
        vt[12] = '{32'h000A_0040, 16'h0540};

        reset     = 1'b1;
        ps2_key   = 11'h400;
        joystick  = '0;
        af_enable = '0;
        m_tog     = 1'b0;
        m_k       = 0;
        repeat (3) step("reset");
        check("reset_pad", int'(pad), 0);

        // Toggle held high through reset must not register as an event.
        reset = 1'b0;
        repeat (10) step("post_reset_idle");
        check("no_spurious_event", int'(pad), 0);

        foreach (vt[i]) begin
            joystick = vt[i].joy;
            step("vector");
            check("vector_pad", int'(pad), int'(vt[i].exp));
        end
        joystick = '0;
        step("clear");

        ps2(1, 0, 8'h29);
        check("f1_key_lat1", int'(pad[4]), 0);
        step("f1_hold");
        check("f1_key_lat2", int'(pad[4]), 1);
        ps2(0, 0, 8'h29);
        check("f1_rel_lat1", int'(pad[4]), 1);
        step("f1_rel");
        check("f1_rel_lat2", int'(pad[4]), 0);
        ps2(1, 1, 8'h75);
        ps2(1, 0, 8'h34);
        step("keys");
        check("ext_up_and_p1_right", int'(pad), 16'h0801);
        ps2(1, 1, 8'h29);
        step("ext_f1");
        check("ext_f1_ignored", int'(pad), 16'h0801);
        ps2(0, 1, 8'h75);
        ps2(0, 0, 8'h34);
        step("keys_off");

        joystick = 32'h0000_000C;
        step("socd_ud");
        check("socd_ud", int'(pad[1:0]), 0);
        joystick = 32'h0000_0008;
        step("socd_up");
        check("socd_up_only", int'(pad[1:0]), 1);
        joystick = '0;
        step("clear");

        joystick = 32'h0000_0100;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step("coin_hold");
            if (i == 0) check("coin_first_cycle", int'(pad[7]), 1);
            cnt += int'(pad[7]);
        end
        check("coin_pulse_once", cnt, CP);
        joystick = '0;
        repeat (2) step("coin_release");
        joystick = 32'h0000_0100;
        cnt = 0;
        repeat (12) begin step("coin_repress"); cnt += int'(pad[7]); end
        check("coin_second_pulse", cnt, CP);

        joystick = '0;
        repeat (2) step("coin_release");
        joystick = 32'h0000_0100;
        repeat (4) step("coin_pulse_part");
        reset = 1'b1;
        step("reset_in_pulse");
        check("coin_cut_by_reset", int'(pad[7]), 0);
        step("reset_in_pulse");
        reset = 1'b0;
        cnt = 0;
        repeat (12) begin step("coin_after_reset"); cnt += int'(pad[7]); end
        check("coin_fresh_pulse", cnt, CP);
        joystick = '0;
        repeat (2) step("clear");

        joystick  = 32'h0000_0010;
        af_enable = 2'b01;
        cnt = 0;
        repeat (16) begin step("autofire"); cnt += int'(pad[4]); end
`ifdef INPUT_AUTOFIRE_EN
        check("autofire_duty", cnt, 8);
`else
        check("autofire_off", cnt, 16);
`endif
        joystick  = '0;
        af_enable = '0;

        for (int i = 0; i < 500; i++) begin
            joystick = (joystick & 32'h0100_0100) | ($urandom & 32'h007F_007F);
            if ($urandom_range(0, 19) == 0) joystick[8]  = ~joystick[8];
            if ($urandom_range(0, 19) == 0) joystick[24] = ~joystick[24];
            if ($urandom_range(0, 19) == 0) af_enable = 2'($urandom);
            reset = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0) begin
                tmp = $urandom_range(0, 21);
                ps2_key[10]  = ~ps2_key[10];
                ps2_key[9]   = 1'($urandom);
                ps2_key[8]   = 1'($urandom);
                ps2_key[7:0] = (tmp < 18) ? ktab[tmp].code : 8'($urandom);
            end
            step("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
